// File: rtl/dm_arb_pkg.sv
// Shared encodings and helpers for the data-memory access arbiter.
// Size codes, FSM states, port ownership and the alignment rule live here.
package dm_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // Size 11 has no legal meaning, so it is reported the same way as a misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatting: store-side write enables and lane replication,
// load-side lane extraction with optional sign extension.
module dm_lane_fmt
  import dm_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wen,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_mis;

  assign w_mis  = misaligned(i_size, i_addr_lo);
  assign w_byte = i_rdata[8*i_addr_lo +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wen = 4'b0000;
    if (!w_mis) begin
      case (i_size)
        SZ_BYTE: o_wen = 4'b0001 << i_addr_lo;
        SZ_HALF: o_wen = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        SZ_WORD: o_wen = 4'b1111;
        default: o_wen = 4'b0000;
      endcase
    end
  end

  // Replicating across all lanes lets the enables alone pick the target bytes.
  always_comb begin
    case (i_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  always_comb begin
    case (i_size)
      SZ_BYTE: o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{i_sign & w_half[15]}}, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Two-port (CPU / debug) arbiter in front of the single data memory array.
// Each access runs IDLE -> ACCESS -> RESP; the CPU wins unless debug has starved.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter  int ADDR_W     = 12,
  parameter  int DATA_W     = 32,
  parameter  int STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sign,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        fsm_state,
  output logic [CNT_W-1:0]  starve_cnt
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dm_access_arbiter: DATA_W must be 32");
  end

  // Handshake: a port holds req (and its fields) until it sees a one-cycle gnt;
  // exactly one cycle later it gets a one-cycle rvalid with rdata/err. No backpressure.

  state_e            r_state;
  state_e            w_next_state;
  owner_e            r_owner;
  logic              r_wr;
  logic              r_sign;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [CNT_W-1:0]  r_starve;

  logic              w_any_req;
  logic              w_dbg_win;
  logic              w_mis;
  logic [3:0]        w_fmt_wen;
  logic [31:0]       w_fmt_wdata;
  logic [31:0]       w_fmt_rdata;

  assign w_any_req = cpu_req | dbg_req;
  assign w_dbg_win = dbg_req & (~cpu_req | (r_starve == CNT_W'(STARVE_MAX)));
  assign w_mis     = misaligned(r_size, r_addr[1:0]);

  dm_lane_fmt u_lane_fmt (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_sign    (r_sign),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_rdata),
    .o_wen     (w_fmt_wen),
    .o_wdata   (w_fmt_wdata),
    .o_rdata   (w_fmt_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Everything visible outside is decoded from registered state, never from req.
  always_comb begin
    cpu_gnt    = (r_state == ACCESS) && (r_owner == OWN_CPU);
    dbg_gnt    = (r_state == ACCESS) && (r_owner == OWN_DBG);
    cpu_rvalid = (r_state == RESP) && (r_owner == OWN_CPU);
    dbg_rvalid = (r_state == RESP) && (r_owner == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? r_rdata : 32'h0;
    dbg_rdata  = dbg_rvalid ? r_rdata : 32'h0;
    cpu_err    = cpu_rvalid & w_mis;
    mem_wen    = ((r_state == ACCESS) && r_wr) ? w_fmt_wen : 4'b0000;
    mem_addr   = r_addr[ADDR_W-1:2];
    mem_wdata  = w_fmt_wdata;
    fsm_state  = r_state;
    starve_cnt = r_starve;
  end

  // Debug accesses are stored as aligned word requests so they share the CPU datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner <= OWN_CPU;
      r_wr    <= 1'b0;
      r_sign  <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else if ((r_state == IDLE) && w_any_req) begin
      if (w_dbg_win) begin
        r_owner <= OWN_DBG;
        r_wr    <= dbg_wr;
        r_sign  <= 1'b0;
        r_size  <= SZ_WORD;
        r_addr  <= dbg_addr & ~ADDR_W'(3);
        r_wdata <= dbg_wdata;
      end else begin
        r_owner <= OWN_CPU;
        r_wr    <= cpu_wr;
        r_sign  <= cpu_sign;
        r_size  <= cpu_size;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0;
    end else if (r_state == ACCESS) begin
      r_rdata <= (!r_wr && !w_mis) ? w_fmt_rdata : 32'h0;
    end
  end

  // Counts arbitration edges a pending debug request loses to the CPU.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      if (w_dbg_win || !dbg_req) begin
        r_starve <= '0;
      end else if (r_starve != CNT_W'(STARVE_MAX)) begin
        r_starve <= r_starve + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter with a behavioural falling-edge memory.
// Expected responses are queued when a request is driven and popped at rvalid.
module tb_dm_access_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_sign = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_wr = 1'b0;
  logic [11:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  fsm_state;
  logic [2:0]  starve_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  logic [31:0] mem [0:1023] = '{default: 32'h0};

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (mem_wen[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  dm_access_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state), .starve_cnt(starve_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic cpu_txn(input logic wr, input logic [1:0] size, input logic sign,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         output logic [3:0] o_wen, output logic [3:0] o_wen_any,
                         output logic [9:0] o_maddr, output logic [31:0] o_mwdata,
                         output logic [32:0] o_resp, output int o_lat, output logic o_to);
    logic got = 1'b0;
    o_wen = '0; o_wen_any = '0; o_maddr = '0; o_mwdata = '0; o_resp = '0; o_lat = 0; o_to = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_sign = sign; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      o_wen_any = o_wen_any | mem_wen;
      if (cpu_gnt) begin
        got = 1'b1; o_lat = c; o_wen = mem_wen; o_maddr = mem_addr; o_mwdata = mem_wdata;
        break;
      end
    end
    cpu_req = 1'b0;
    if (!got) begin
      o_to = 1'b1;
    end else begin
      got = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        o_wen_any = o_wen_any | mem_wen;
        if (cpu_rvalid) begin
          got = 1'b1; o_resp = {cpu_err, cpu_rdata};
          break;
        end
      end
      if (!got) o_to = 1'b1;
    end
  endtask

  task automatic dbg_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                         output logic [3:0] o_wen, output logic [9:0] o_maddr,
                         output logic [31:0] o_mwdata, output logic [32:0] o_resp, output logic o_to);
    logic got = 1'b0;
    o_wen = '0; o_maddr = '0; o_mwdata = '0; o_resp = '0; o_to = 1'b0;
    @(negedge clk);
    dbg_req = 1'b1; dbg_wr = wr; dbg_addr = addr; dbg_wdata = wdata;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (dbg_gnt) begin
        got = 1'b1; o_wen = mem_wen; o_maddr = mem_addr; o_mwdata = mem_wdata;
        break;
      end
    end
    dbg_req = 1'b0;
    if (!got) begin
      o_to = 1'b1;
    end else begin
      got = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (dbg_rvalid) begin
          got = 1'b1; o_resp = {1'b0, dbg_rdata};
          break;
        end
      end
      if (!got) o_to = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [32:0] exp;
    resetn = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = SZ_WORD; cpu_sign = 1'b0; cpu_addr = 12'h000;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, dbg_gnt, dbg_rvalid, dbg_rdata,
         mem_addr, mem_wen, mem_wdata, fsm_state, starve_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: gnt=%b rv=%b rdata=%h err=%b wen=%b maddr=%h wdata=%h st=%0d cnt=%0d, required all 0",
               cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, mem_wen, mem_addr, mem_wdata, fsm_state, starve_cnt);
    end
    exp_q.push_back({1'b0, 32'h0});
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt !== 1'b1) begin n_errors++; $display("FAIL reset_first_gnt: cpu_gnt=%b required 1", cpu_gnt); end
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, cpu_rvalid} !== 2'b01) begin
      n_errors++; $display("FAIL reset_first_rvalid: gnt,rvalid=%b required 01", {cpu_gnt, cpu_rvalid});
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({cpu_err, cpu_rdata} !== exp) begin
      n_errors++; $display("FAIL reset_first_resp: got %h required %h", {cpu_err, cpu_rdata}, exp);
    end
  endtask

  task automatic test_byte;
    logic [3:0] wen, wen_any; logic [9:0] ma; logic [31:0] mwd; logic [32:0] resp, exp; int lat; logic to;
    exp_q.push_back({1'b0, 32'h0});
    cpu_txn(1'b1, SZ_BYTE, 1'b0, 12'h013, 32'h1234_56A5, wen, wen_any, ma, mwd, resp, lat, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL byte_st_timeout: no gnt/rvalid"); end
    n_checks++; if (lat != 1) begin n_errors++; $display("FAIL byte_st_latency: gnt after %0d cycles required 1", lat); end
    n_checks++; if (wen !== 4'b1000) begin n_errors++; $display("FAIL byte_st_wen: %b required 1000", wen); end
    n_checks++; if (ma !== 10'h004) begin n_errors++; $display("FAIL byte_st_maddr: %h required 004", ma); end
    n_checks++; if (mwd !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL byte_st_wdata: %h required a5a5a5a5", mwd); end
    exp = exp_q.pop_front();
    n_checks++; if (resp !== exp) begin n_errors++; $display("FAIL byte_st_resp: %h required %h", resp, exp); end
    exp_q.push_back({1'b0, 32'hFFFF_FFA5});
    cpu_txn(1'b0, SZ_BYTE, 1'b1, 12'h013, 32'h0, wen, wen_any, ma, mwd, resp, lat, to);
    exp = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || resp !== exp) begin n_errors++; $display("FAIL byte_ld_signed: %h to=%b required %h", resp, to, exp); end
    n_checks++; if (wen_any !== 4'b0000) begin n_errors++; $display("FAIL byte_ld_wen: %b required 0000", wen_any); end
    exp_q.push_back({1'b0, 32'h0000_00A5});
    cpu_txn(1'b0, SZ_BYTE, 1'b0, 12'h013, 32'h0, wen, wen_any, ma, mwd, resp, lat, to);
    exp = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || resp !== exp) begin n_errors++; $display("FAIL byte_ld_unsigned: %h to=%b required %h", resp, to, exp); end
  endtask

  task automatic test_half;
    logic [3:0] wen, wen_any; logic [9:0] ma; logic [31:0] mwd; logic [32:0] resp, exp; int lat; logic to;
    logic [11:0] ld_addr [3] = '{12'h022, 12'h022, 12'h020};
    logic [1:0]  ld_size [3] = '{SZ_HALF, SZ_HALF, SZ_WORD};
    logic        ld_sign [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ld_exp  [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
    exp_q.push_back({1'b0, 32'h0});
    cpu_txn(1'b1, SZ_HALF, 1'b0, 12'h022, 32'hBEEF_8001, wen, wen_any, ma, mwd, resp, lat, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL half_st_timeout: no gnt/rvalid"); end
    n_checks++; if (wen !== 4'b1100) begin n_errors++; $display("FAIL half_st_wen: %b required 1100", wen); end
    n_checks++; if (mwd !== 32'h8001_8001) begin n_errors++; $display("FAIL half_st_wdata: %h required 80018001", mwd); end
    exp = exp_q.pop_front();
    n_checks++; if (resp !== exp) begin n_errors++; $display("FAIL half_st_resp: %h required %h", resp, exp); end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, ld_exp[k]});
      cpu_txn(1'b0, ld_size[k], ld_sign[k], ld_addr[k], 32'h0, wen, wen_any, ma, mwd, resp, lat, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to !== 1'b0 || resp !== exp) begin
        n_errors++; $display("FAIL half_ld_%0d: %h to=%b required %h", k, resp, to, exp);
      end
    end
  endtask

  task automatic test_misaligned;
    logic [3:0] wen, wen_any; logic [9:0] ma; logic [31:0] mwd; logic [32:0] resp, exp; int lat; logic to;
    logic        t_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_size [4] = '{SZ_WORD, SZ_HALF, 2'b11, SZ_WORD};
    logic [11:0] t_addr [4] = '{12'h005, 12'h003, 12'h000, 12'h000};
    logic [32:0] t_exp  [4] = '{{1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'h0}};
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(t_exp[k]);
      cpu_txn(t_wr[k], t_size[k], 1'b1, t_addr[k], 32'hFFFF_FFFF, wen, wen_any, ma, mwd, resp, lat, to);
      n_checks++; if (wen_any !== 4'b0000) begin n_errors++; $display("FAIL mis_wen_%0d: %b required 0000", k, wen_any); end
      exp = exp_q.pop_front();
      n_checks++;
      if (to !== 1'b0 || resp !== exp) begin
        n_errors++; $display("FAIL mis_resp_%0d: err,rdata=%h to=%b required %h", k, resp, to, exp);
      end
    end
  endtask

  task automatic test_dbg;
    logic [3:0] wen, wen_any; logic [9:0] ma; logic [31:0] mwd; logic [32:0] resp, exp; int lat; logic to;
    exp_q.push_back({1'b0, 32'h0});
    dbg_txn(1'b1, 12'h083, 32'h1234_5678, wen, ma, mwd, resp, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL dbg_wr_timeout: no gnt/rvalid"); end
    n_checks++;
    if ({wen, ma, mwd} !== {4'b1111, 10'h020, 32'h1234_5678}) begin
      n_errors++; $display("FAIL dbg_wr_mem: wen=%b maddr=%h wdata=%h required 1111/020/12345678", wen, ma, mwd);
    end
    exp = exp_q.pop_front();
    n_checks++; if (resp !== exp) begin n_errors++; $display("FAIL dbg_wr_resp: %h required %h", resp, exp); end
    exp_q.push_back({1'b0, 32'h1234_5678});
    dbg_txn(1'b0, 12'h080, 32'h0, wen, ma, mwd, resp, to);
    exp = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || resp !== exp) begin n_errors++; $display("FAIL dbg_rd: %h to=%b required %h", resp, to, exp); end
    exp_q.push_back({1'b0, 32'h0000_0056});
    cpu_txn(1'b0, SZ_BYTE, 1'b1, 12'h081, 32'h0, wen, wen_any, ma, mwd, resp, lat, to);
    exp = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || resp !== exp) begin n_errors++; $display("FAIL cpu_byte_lane1: %h required %h", resp, exp); end
    exp_q.push_back({1'b0, 32'h0000_1234});
    cpu_txn(1'b0, SZ_HALF, 1'b1, 12'h082, 32'h0, wen, wen_any, ma, mwd, resp, lat, to);
    exp = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || resp !== exp) begin n_errors++; $display("FAIL cpu_half_hi: %h required %h", resp, exp); end
  endtask

  task automatic test_starvation;
    logic [32:0] exp, obs;
    int grants = 0;
    int last = 0;
    logic [3:0] e_cnt [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
    logic       e_own [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) exp_q.push_back({28'h0, e_own[k], e_cnt[k]});
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = SZ_WORD; cpu_sign = 1'b0; cpu_addr = 12'h020;
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 12'h080;
    for (int c = 1; c <= 40 && grants < 6; c++) begin
      @(negedge clk);
      if (cpu_gnt || dbg_gnt) begin
        obs = {28'h0, dbg_gnt, 1'b0, starve_cnt};
        exp = exp_q.pop_front();
        n_checks++;
        if ((cpu_gnt & dbg_gnt) || obs !== exp) begin
          n_errors++;
          $display("FAIL starve_grant_%0d: cpu_gnt=%b dbg_gnt=%b cnt=%0d required owner=%b cnt=%0d",
                   grants, cpu_gnt, dbg_gnt, starve_cnt, exp[3], exp[2:0]);
        end
        n_checks++;
        if (c - last != ((grants == 0) ? 1 : 3)) begin
          n_errors++; $display("FAIL starve_spacing_%0d: %0d cycles", grants, c - last);
        end
        last = c;
        grants++;
        if (dbg_gnt) dbg_req = 1'b0;
        if (grants == 6) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    n_checks++;
    if (grants != 6) begin
      n_errors++; $display("FAIL starve_timeout: %0d grants required 6", grants);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    logic [3:0] wen, wen_any; logic [9:0] ma; logic [31:0] mwd; logic [32:0] resp, exp; int lat; logic to;
    logic got = 1'b0;
    logic saw_rv = 1'b0;
    dbg_txn(1'b1, 12'h040, 32'h1122_3344, wen, ma, mwd, resp, to);
    n_checks++; if (to !== 1'b0 || wen !== 4'b1111) begin n_errors++; $display("FAIL rst_preload: wen=%b to=%b", wen, to); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = SZ_WORD; cpu_sign = 1'b0; cpu_addr = 12'h040; cpu_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (cpu_gnt) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got || mem_wen !== 4'b1111) begin
      n_errors++; $display("FAIL rst_mid_setup: gnt seen=%b wen=%b required 1/1111", got, mem_wen);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({mem_wen, cpu_gnt} !== 5'b0) begin
      n_errors++; $display("FAIL rst_mid_wen_drop: wen=%b gnt=%b required 0000/0", mem_wen, cpu_gnt);
    end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_rvalid || dbg_rvalid || cpu_gnt) saw_rv = 1'b1;
    end
    n_checks++; if (saw_rv) begin n_errors++; $display("FAIL rst_mid_no_resp: activity seen after release"); end
    n_checks++;
    if (mem[16] !== 32'h1122_3344) begin
      n_errors++; $display("FAIL rst_mid_mem: word 0x040=%h required 11223344", mem[16]);
    end
    exp_q.push_back({1'b0, 32'h1122_3344});
    cpu_txn(1'b0, SZ_WORD, 1'b0, 12'h040, 32'h0, wen, wen_any, ma, mwd, resp, lat, to);
    exp = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || resp !== exp) begin n_errors++; $display("FAIL rst_mid_readback: %h required %h", resp, exp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_byte();
    test_half();
    test_misaligned();
    test_dbg();
    test_starvation();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
